haar_stage_evaluator: RTL and testbench
=======================================

// Module: haar_stage_evaluator
// PURPOSE
//  Consumer end of the cascade database read stream: takes one stage's parameter words (18 per
//  classifier + NUM_STAGE_THRESHOLD stage words) as emitted by a cascade ROM reader. Evaluates each
//  Haar classifier against the current INTEGRAL_WIDTH x INTEGRAL_HEIGHT integral window, accumulates
//  left/right votes, and reports stage pass/fail. One instance per stage, fed by that stage's reader.
// PARAMETERS
//  DATA_WIDTH_12            12  database word width; all words signed two's complement
//  DATA_WIDTH_16            16  integral image element width (unsigned)
//  INTEGRAL_WIDTH            8  window columns
//  INTEGRAL_HEIGHT           8  window rows
//  NUM_CLASSIFIERS           9  classifiers in this stage (>=1)
//  NUM_PARAM_PER_CLASSIFIER 18  words per classifier (fixed layout below)
//  NUM_STAGE_THRESHOLD       3  stage trailer words
// PORTS
//  clk_fpga                in  1    clock
//  reset_fpga              in  1    async reset, active high
//  i_start                 in  1    1-cycle pulse: begin a stage evaluation
//  i_integral_image        in  W*H*DATA_WIDTH_16  flattened window, element idx=row*W+col, LSB=idx0
//  i_valid                 in  1    i_data carries a database word
//  i_data                  in  DATA_WIDTH_12  database word
//  i_end_single_classifier in  1    reader flag, asserted with the last word of a classifier
//  i_end_all_classifier    in  1    reader flag, asserted with the last stage trailer word
//  o_ready                 out 1    word accepted when i_valid && o_ready
//  o_busy                  out 1    evaluation in progress
//  o_done                  out 1    1-cycle pulse, o_pass/o_stage_sum valid from this cycle
//  o_pass                  out 1    stage passed; held until next i_start
//  o_stage_sum             out 16   signed vote accumulator; held until next i_start
//  o_error                 out 1    sticky until next i_start: bad corner or flag mismatch
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; accumulators and counters 0.
//  Word layout per classifier (word k): rect r=0..2 at k=5r..5r+4 = x,y,w,h,weight;
//   k=15 classifier threshold; k=16 left vote; k=17 right vote. Trailer word0 = stage threshold;
//   trailer words 1..NUM_STAGE_THRESHOLD-1 consumed and ignored.
//  FSM: IDLE -i_start-> RECV (clear feature/stage acc, error, pass, counters).
//   RECV: o_ready=1; each accepted word advances word counter. On weight word: corners A=(y,x),
//    B=(y,x+w), C=(y+h,x), D=(y+h,x+w); rectsum=D-B-C+A (unsigned 16); feature_acc(signed 32)
//    += weight*rectsum. On k=17 -> CLASSIFY.
//   CLASSIFY (1 cycle, o_ready=0): stage_acc += (feature_acc < sext(threshold)) ? left : right;
//    feature_acc cleared; classifier counter++; if last classifier -> TRAIL else RECV.
//   TRAIL: o_ready=1; word0 latched as stage threshold; after last trailer word -> DONE.
//   DONE (1 cycle): o_done=1, o_pass=(stage_acc >= sext(stage threshold)); -> IDLE.
//  Latency: last trailer word accepted at cycle t -> o_done at t+1. Total stage time
//   = NUM_CLASSIFIERS*19 + NUM_STAGE_THRESHOLD + 1 cycles with i_valid held high.
//  i_valid low: counters/accumulators hold; no timeout. i_valid while o_ready=0: word not consumed;
//   source must hold it. i_valid in IDLE ignored.
//  Any corner row >= H or col >= W: that rect contributes 0, o_error set; evaluation continues.
//  i_end_single_classifier must equal (k==17) on every accepted classifier word, and
//   i_end_all_classifier must equal (last trailer word) on every accepted word; mismatch sets
//   o_error, flow still follows internal counters.
//  i_start while o_busy: ignored. Reset mid-stream: immediate return to IDLE, all outputs 0.
//  i_integral_image must be stable from i_start to o_done; block does not snapshot it.
//  stage_acc wraps at 16 bits, no saturation.
// TESTING
//  Window pixel=1 everywhere (II[r][c]=(r+1)(c+1)), NUM_CLASSIFIERS=1, rect0 (0,0,2,2) weight 3,
//   rects1/2 weight 0, thr 10, left -4, right 5, stage thr 5 -> feature 12, o_stage_sum=5, o_pass=1.
//  Same, classifier thr 20 -> left taken, o_stage_sum=-4 (0xFFFC), o_pass=0, o_error=0.
//  Same as first, i_valid toggled 1/0 every cycle -> identical result; o_ready low exactly in
//   CLASSIFY.
//  rect0 x=7,w=2 -> rect contributes 0, o_error=1, o_done still pulses once.
//  Assert reset_fpga at word 9 -> all outputs 0 next edge; fresh i_start replays test 1 -> o_pass=1.
//  i_end_single_classifier asserted at k=16 -> o_error=1, result unchanged from test 1.

Source files
------------

// File: rtl/haar_stage_evaluator.sv
// Haar cascade stage evaluator.
// Consumes one stage's database words from a cascade ROM reader and evaluates every
// classifier against the current integral window. Each classifier votes left or right,
// and the summed votes are compared against the stage threshold to give pass or fail.
//
// Handshake: a word transfers on a rising clk_fpga edge where i_valid && o_ready.
// o_ready is high only while receiving classifier or trailer words. While o_ready is
// low, the source must hold the word. i_valid outside an evaluation is ignored.
module haar_stage_evaluator #(
    parameter int DATA_WIDTH_12            = 12,
    parameter int DATA_WIDTH_16            = 16,
    parameter int INTEGRAL_WIDTH           = 8,
    parameter int INTEGRAL_HEIGHT          = 8,
    parameter int NUM_CLASSIFIERS          = 9,
    parameter int NUM_PARAM_PER_CLASSIFIER = 18,
    parameter int NUM_STAGE_THRESHOLD      = 3
) (
    input  logic                                                     clk_fpga,
    input  logic                                                     reset_fpga,
    input  logic                                                     i_start,
    input  logic [INTEGRAL_WIDTH*INTEGRAL_HEIGHT*DATA_WIDTH_16-1:0]  i_integral_image,
    input  logic                                                     i_valid,
    input  logic [DATA_WIDTH_12-1:0]                                 i_data,
    input  logic                                                     i_end_single_classifier,
    input  logic                                                     i_end_all_classifier,
    output logic                                                     o_ready,
    output logic                                                     o_busy,
    output logic                                                     o_done,
    output logic                                                     o_pass,
    output logic [15:0]                                              o_stage_sum,
    output logic                                                     o_error,
    output logic [2:0]                                               o_dbg_state
);

    // Coordinates are sign-extended by one bit so that x+w and y+h cannot overflow.
    localparam int CW = DATA_WIDTH_12 + 1;
    localparam int KW = $clog2(NUM_PARAM_PER_CLASSIFIER);
    localparam int NW = $clog2(NUM_CLASSIFIERS + 1);
    localparam int TW = $clog2(NUM_STAGE_THRESHOLD + 1);

    localparam logic [KW-1:0] K_THR      = KW'(NUM_PARAM_PER_CLASSIFIER - 3);
    localparam logic [KW-1:0] K_LEFT     = KW'(NUM_PARAM_PER_CLASSIFIER - 2);
    localparam logic [KW-1:0] K_RIGHT    = KW'(NUM_PARAM_PER_CLASSIFIER - 1);
    localparam logic [NW-1:0] CLS_LAST   = NW'(NUM_CLASSIFIERS - 1);
    localparam logic [TW-1:0] TRAIL_LAST = TW'(NUM_STAGE_THRESHOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RECV     = 3'd1,
        S_CLASSIFY = 3'd2,
        S_TRAIL    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                     state;
    logic [KW-1:0]              word_cnt;
    logic [2:0]                 field_cnt;
    logic [NW-1:0]              cls_cnt;
    logic [TW-1:0]              trail_cnt;
    logic [DATA_WIDTH_12-1:0]   x_reg, y_reg, w_reg, h_reg;
    logic [DATA_WIDTH_12-1:0]   thr_reg, left_reg, right_reg, stage_thr_reg;
    logic signed [31:0]         feature_acc;
    logic [15:0]                stage_acc;

    logic signed [CW-1:0]       col_lo, col_hi, row_lo, row_hi;
    logic                       rect_ok;
    logic [DATA_WIDTH_16-1:0]   corner_a, corner_b, corner_c, corner_d;
    logic [DATA_WIDTH_16-1:0]   rect_sum;
    logic signed [31:0]         weight_ext, rect_term, thr_ext;
    logic [DATA_WIDTH_12-1:0]   vote, stage_thr_now;
    logic [15:0]                vote_ext, stage_thr_ext;
    logic                       pass_now;
    logic                       accept;
    logic                       flag_bad;

    assign o_dbg_state = state;
    assign accept      = i_valid && o_ready;

    // A coordinate is usable when it is non-negative and below the window limit.
    function automatic logic coord_ok(input logic signed [CW-1:0] v, input int limit);
        return !v[CW-1] && ($unsigned(v) < CW'(limit));
    endfunction

    // Integral element at (row, col); out-of-window positions read as zero.
    function automatic logic [DATA_WIDTH_16-1:0] elem(input logic signed [CW-1:0] r,
                                                       input logic signed [CW-1:0] c);
        int idx;
        idx = int'(r) * INTEGRAL_WIDTH + int'(c);
        if (idx < 0 || idx >= INTEGRAL_WIDTH * INTEGRAL_HEIGHT)
            return '0;
        return i_integral_image[idx*DATA_WIDTH_16 +: DATA_WIDTH_16];
    endfunction

    // Rectangle sum and weighted term for the weight word currently on i_data.
    always_comb begin
        col_lo     = $signed({x_reg[DATA_WIDTH_12-1], x_reg});
        col_hi     = col_lo + $signed({w_reg[DATA_WIDTH_12-1], w_reg});
        row_lo     = $signed({y_reg[DATA_WIDTH_12-1], y_reg});
        row_hi     = row_lo + $signed({h_reg[DATA_WIDTH_12-1], h_reg});
        rect_ok    = coord_ok(row_lo, INTEGRAL_HEIGHT) && coord_ok(row_hi, INTEGRAL_HEIGHT) &&
                     coord_ok(col_lo, INTEGRAL_WIDTH)  && coord_ok(col_hi, INTEGRAL_WIDTH);
        corner_a   = elem(row_lo, col_lo);
        corner_b   = elem(row_lo, col_hi);
        corner_c   = elem(row_hi, col_lo);
        corner_d   = elem(row_hi, col_hi);
        rect_sum   = corner_d - corner_b - corner_c + corner_a;
        weight_ext = $signed({{(32-DATA_WIDTH_12){i_data[DATA_WIDTH_12-1]}}, i_data});
        rect_term  = rect_ok ? weight_ext * $signed({{(32-DATA_WIDTH_16){1'b0}}, rect_sum}) : '0;
    end

    // Classifier vote and stage pass decision.
    always_comb begin
        thr_ext       = $signed({{(32-DATA_WIDTH_12){thr_reg[DATA_WIDTH_12-1]}}, thr_reg});
        vote          = (feature_acc < thr_ext) ? left_reg : right_reg;
        vote_ext      = {{(16-DATA_WIDTH_12){vote[DATA_WIDTH_12-1]}}, vote};
        // With a single trailer word the threshold is still on the bus when the decision is made.
        stage_thr_now = (trail_cnt == '0) ? i_data : stage_thr_reg;
        stage_thr_ext = {{(16-DATA_WIDTH_12){stage_thr_now[DATA_WIDTH_12-1]}}, stage_thr_now};
        pass_now      = $signed(stage_acc) >= $signed(stage_thr_ext);
    end

    // Reader flags must agree with our own word position.
    always_comb begin
        flag_bad = 1'b0;
        if (state == S_RECV)
            flag_bad = (i_end_single_classifier != (word_cnt == K_RIGHT)) || i_end_all_classifier;
        else if (state == S_TRAIL)
            flag_bad = (i_end_all_classifier != (trail_cnt == TRAIL_LAST));
    end

    // Evaluation FSM with registered handshake and result outputs.
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            state         <= S_IDLE;
            word_cnt      <= '0;
            field_cnt     <= '0;
            cls_cnt       <= '0;
            trail_cnt     <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            w_reg         <= '0;
            h_reg         <= '0;
            thr_reg       <= '0;
            left_reg      <= '0;
            right_reg     <= '0;
            stage_thr_reg <= '0;
            feature_acc   <= '0;
            stage_acc     <= '0;
            o_ready       <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_pass        <= 1'b0;
            o_stage_sum   <= '0;
            o_error       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state       <= S_RECV;
                        o_ready     <= 1'b1;
                        o_busy      <= 1'b1;
                        o_error     <= 1'b0;
                        o_pass      <= 1'b0;
                        o_stage_sum <= '0;
                        feature_acc <= '0;
                        stage_acc   <= '0;
                        word_cnt    <= '0;
                        field_cnt   <= '0;
                        cls_cnt     <= '0;
                        trail_cnt   <= '0;
                    end
                end
                S_RECV: begin
                    if (accept) begin
                        if (flag_bad)
                            o_error <= 1'b1;
                        if (word_cnt < K_THR) begin
                            case (field_cnt)
                                3'd0:    x_reg <= i_data;
                                3'd1:    y_reg <= i_data;
                                3'd2:    w_reg <= i_data;
                                3'd3:    h_reg <= i_data;
                                default: begin
                                    feature_acc <= feature_acc + rect_term;
                                    if (!rect_ok)
                                        o_error <= 1'b1;
                                end
                            endcase
                            field_cnt <= (field_cnt == 3'd4) ? 3'd0 : field_cnt + 3'd1;
                        end else if (word_cnt == K_THR) begin
                            thr_reg <= i_data;
                        end else if (word_cnt == K_LEFT) begin
                            left_reg <= i_data;
                        end else begin
                            right_reg <= i_data;
                        end
                        if (word_cnt == K_RIGHT) begin
                            word_cnt <= '0;
                            state    <= S_CLASSIFY;
                            o_ready  <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt + KW'(1);
                        end
                    end
                end
                S_CLASSIFY: begin
                    stage_acc   <= stage_acc + vote_ext;
                    feature_acc <= '0;
                    o_ready     <= 1'b1;
                    if (cls_cnt == CLS_LAST) begin
                        state <= S_TRAIL;
                    end else begin
                        cls_cnt <= cls_cnt + NW'(1);
                        state   <= S_RECV;
                    end
                end
                S_TRAIL: begin
                    if (accept) begin
                        if (flag_bad)
                            o_error <= 1'b1;
                        if (trail_cnt == '0)
                            stage_thr_reg <= i_data;
                        if (trail_cnt == TRAIL_LAST) begin
                            state       <= S_DONE;
                            o_ready     <= 1'b0;
                            o_done      <= 1'b1;
                            o_pass      <= pass_now;
                            o_stage_sum <= stage_acc;
                        end else begin
                            trail_cnt <= trail_cnt + TW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    o_ready <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_haar_stage_evaluator.sv
// Bench for haar_stage_evaluator: directed stage scenarios plus randomized stages scored
// against a plain-arithmetic reference of the cascade stage.
module tb_haar_stage_evaluator;

    localparam int D12    = 12;
    localparam int D16    = 16;
    localparam int W      = 8;
    localparam int H      = 8;
    localparam int NCLS   = 3;
    localparam int NPAR   = 18;
    localparam int NST    = 3;
    localparam int NWORDS = NCLS * NPAR + NST;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic                 i_start;
    logic [W*H*D16-1:0]   image_bus;
    logic                 i_valid;
    logic [D12-1:0]       i_data;
    logic                 i_end_single;
    logic                 i_end_all;
    logic                 o_ready, o_busy, o_done, o_pass, o_error;
    logic [15:0]          o_stage_sum;
    logic [2:0]           o_dbg_state;

    haar_stage_evaluator #(
        .DATA_WIDTH_12            (D12),
        .DATA_WIDTH_16            (D16),
        .INTEGRAL_WIDTH           (W),
        .INTEGRAL_HEIGHT          (H),
        .NUM_CLASSIFIERS          (NCLS),
        .NUM_PARAM_PER_CLASSIFIER (NPAR),
        .NUM_STAGE_THRESHOLD      (NST)
    ) dut (
        .clk_fpga                (clk),
        .reset_fpga              (rst),
        .i_start                 (i_start),
        .i_integral_image        (image_bus),
        .i_valid                 (i_valid),
        .i_data                  (i_data),
        .i_end_single_classifier (i_end_single),
        .i_end_all_classifier    (i_end_all),
        .o_ready                 (o_ready),
        .o_busy                  (o_busy),
        .o_done                  (o_done),
        .o_pass                  (o_pass),
        .o_stage_sum             (o_stage_sum),
        .o_error                 (o_error),
        .o_dbg_state             (o_dbg_state)
    );

    // ---------------- bench state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] exp_q[$];      // {error, pass, stage_sum}
    int          lat_q[$];      // expected start-to-done cycles, -1 when not checked
    int          stim[NWORDS];
    int          ii[H][W];
    int          start_cyc = 0;
    int          done_cnt  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic build_image(input logic ones);
        int pix[H][W];
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                pix[r][c] = ones ? 1 : int'($urandom_range(0, 15));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                ii[r][c] = 0;
                for (int rr = 0; rr <= r; rr++)
                    for (int cc = 0; cc <= c; cc++)
                        ii[r][c] += pix[rr][cc];
                image_bus[(r*W+c)*D16 +: D16] = 16'(ii[r][c]);
            end
    endtask

    function automatic logic in_win(input int r, input int c);
        return (r >= 0) && (r < H) && (c >= 0) && (c < W);
    endfunction

    task automatic model_stage(input int bad_flag, output logic [17:0] res);
        int   feat, acc, x, y, w, h, wt, rs, base;
        logic err;
        logic [15:0] sum16;
        err = (bad_flag >= 0);
        acc = 0;
        for (int c = 0; c < NCLS; c++) begin
            base = c * NPAR;
            feat = 0;
            for (int r = 0; r < 3; r++) begin
                x  = stim[base + 5*r];
                y  = stim[base + 5*r + 1];
                w  = stim[base + 5*r + 2];
                h  = stim[base + 5*r + 3];
                wt = stim[base + 5*r + 4];
                if (in_win(y, x) && in_win(y + h, x + w)) begin
                    rs = (ii[y+h][x+w] - ii[y][x+w] - ii[y+h][x] + ii[y][x]) & 32'hFFFF;
                    feat += wt * rs;
                end else begin
                    err = 1'b1;
                end
            end
            acc += (feat < stim[base + 15]) ? stim[base + 16] : stim[base + 17];
        end
        sum16 = acc[15:0];
        res = {err, ($signed(sum16) >= stim[NCLS*NPAR]), sum16};
    endtask

    // ---------------- stimulus builders ----------------
    task automatic set_directed(input int thr, input int x0, input int w0);
        foreach (stim[i]) stim[i] = 0;
        stim[0]  = x0;
        stim[1]  = 0;
        stim[2]  = w0;
        stim[3]  = 2;
        stim[4]  = 3;
        stim[15] = thr;
        stim[16] = -4;
        stim[17] = 5;
        stim[NCLS*NPAR]     = 5;
        stim[NCLS*NPAR + 1] = 37;
        stim[NCLS*NPAR + 2] = -12;
    endtask

    task automatic set_random();
        int base, x, y, w, h;
        for (int c = 0; c < NCLS; c++) begin
            base = c * NPAR;
            for (int r = 0; r < 3; r++) begin
                x = int'($urandom_range(0, W-1));
                y = int'($urandom_range(0, H-1));
                w = int'($urandom_range(0, W-1-x));
                h = int'($urandom_range(0, H-1-y));
                case ($urandom_range(0, 11))
                    0: w = W - x + int'($urandom_range(0, 2));
                    1: h = H - y + int'($urandom_range(0, 2));
                    2: begin x = -1; w = 1; end
                    default: ;
                endcase
                stim[base + 5*r]     = x;
                stim[base + 5*r + 1] = y;
                stim[base + 5*r + 2] = w;
                stim[base + 5*r + 3] = h;
                stim[base + 5*r + 4] = int'($urandom_range(0, 8)) - 4;
            end
            stim[base + 15] = int'($urandom_range(0, 200)) - 100;
            stim[base + 16] = int'($urandom_range(0, 200)) - 100;
            stim[base + 17] = int'($urandom_range(0, 200)) - 100;
        end
        stim[NCLS*NPAR] = int'($urandom_range(0, 300)) - 150;
        for (int t = 1; t < NST; t++)
            stim[NCLS*NPAR + t] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_word(input int val, input logic es, input logic ea);
        logic got;
        got          = 1'b0;
        i_valid      = 1'b1;
        i_data       = 12'(val);
        i_end_single = es;
        i_end_all    = ea;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (o_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        i_valid      = 1'b0;
        i_end_single = 1'b0;
        i_end_all    = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL word_accept_timeout got ready=0 expected ready=1");
        end
    endtask

    task automatic run_stage(input int gap, input int bad_flag, input int start_at,
                             input int abort_at, input logic use_lit, input logic [17:0] lit);
        logic [17:0] res;
        logic        es, ea;
        int          d0;
        d0 = done_cnt;
        if (abort_at < 0) begin
            if (use_lit) res = lit;
            else model_stage(bad_flag, res);
            exp_q.push_back(res);
            lat_q.push_back(gap == 0 ? NCLS*19 + NST : -1);
        end
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < NWORDS; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("reset_mid_stream",
                      {8'd0, o_ready, o_busy, o_done, o_pass, o_error, o_stage_sum, o_dbg_state}, 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            if (gap != 0) begin
                @(posedge clk);
                #1;
            end
            es = (i < NCLS*NPAR) && (i % NPAR == NPAR - 1);
            ea = (i == NWORDS - 1);
            if (i == bad_flag) begin
                if (i < NCLS*NPAR) es = !es;
                else ea = !ea;
            end
            if (i == start_at) i_start = 1'b1;
            send_word(stim[i], es, ea);
            i_start = 1'b0;
        end
        for (int t = 0; t < 20 && done_cnt == d0; t++) @(posedge clk);
        if (done_cnt == d0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout got no o_done expected one pulse");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    int          stall_cnt = 0;
    logic        prev_done = 1'b0;
    logic [17:0] last_exp  = '0;

    always @(negedge clk) begin
        logic [17:0] e;
        int          lat;
        if (rst) begin
            stall_cnt = 0;
            prev_done = 1'b0;
        end else begin
            if (o_busy && !o_ready && !o_done) stall_cnt++;
            if (prev_done) begin
                check("done_single_pulse", {31'd0, o_done}, 32'd0);
                check("result_held", {14'd0, o_error, o_pass, o_stage_sum}, {14'd0, last_exp});
            end
            if (o_done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done got o_done=1 expected no result");
                end else begin
                    e   = exp_q.pop_front();
                    lat = lat_q.pop_front();
                    check("stage_sum", {16'd0, o_stage_sum}, {16'd0, e[15:0]});
                    check("pass", {31'd0, o_pass}, {31'd0, e[16]});
                    check("error", {31'd0, o_error}, {31'd0, e[17]});
                    check("ready_low_cycles", stall_cnt, NCLS);
                    if (lat >= 0) check("latency", cyc - start_cyc, lat);
                    last_exp = e;
                end
                stall_cnt = 0;
            end
            prev_done = o_done;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [17:0] t1_res;
        rst          = 1'b1;
        i_start      = 1'b0;
        i_valid      = 1'b0;
        i_data       = '0;
        i_end_single = 1'b0;
        i_end_all    = 1'b0;
        image_bus    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {8'd0, o_ready, o_busy, o_done, o_pass, o_error, o_stage_sum, o_dbg_state}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Words offered while idle must not be accepted.
        i_valid = 1'b1;
        i_data  = 12'h123;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", {30'd0, o_ready, o_busy}, 32'd0);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;

        build_image(1'b1);
        t1_res = {1'b0, 1'b1, 16'd5};

        set_directed(10, 0, 2);
        run_stage(0, -1, -1, -1, 1'b1, t1_res);
        set_directed(20, 0, 2);
        run_stage(0, -1, -1, -1, 1'b1, {1'b0, 1'b0, 16'hFFFC});
        set_directed(10, 0, 2);
        run_stage(1, -1, -1, -1, 1'b1, t1_res);
        set_directed(10, 7, 2);
        run_stage(0, -1, -1, -1, 1'b1, {1'b1, 1'b0, 16'hFFFC});
        set_directed(10, 0, 2);
        run_stage(0, -1, -1, 9, 1'b1, t1_res);
        run_stage(0, -1, -1, -1, 1'b1, t1_res);
        run_stage(0, 16, -1, -1, 1'b1, {1'b1, 1'b1, 16'd5});
        run_stage(0, -1, 5, -1, 1'b1, t1_res);

        for (int s = 0; s < 16; s++) begin
            int gap, bad, st;
            build_image(1'b0);
            set_random();
            gap = ($urandom_range(0, 3) == 0) ? 1 : 0;
            bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NWORDS-1)) : -1;
            st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NWORDS-1)) : -1;
            run_stage(gap, bad, st, -1, 1'b0, '0);
        end

        repeat (5) @(posedge clk);
        while (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_tests++;
            n_fail++;
            $display("FAIL missing_done got nothing expected a stage result");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog got no finish expected end of run");
        $fatal(1, "watchdog expired");
    end

endmodule
